// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// presenting both a parallel sum/carry-out and a qualified serial sum stream.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit pair added per edge
// DONE  | result just completed; start here reloads without an idle bubble
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             sbit,
    output logic             sbit_valid
);

    generate
        if (WIDTH < 2 || WIDTH > 32 || (2 ** CNT_W) < WIDTH) begin : g_param_check
            $error("serial_adder: WIDTH must be 2..32 and 2**CNT_W >= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             bit_sum;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] sum_nxt;

    // The A shift register doubles as the sum register: each consumed A bit
    // frees the MSB slot that receives the new sum bit.
    always_comb begin
        bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
        sum_nxt   = {bit_sum, a_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s          <= '0;
            co         <= 1'b0;
            sbit       <= 1'b0;
            sbit_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done       <= 1'b0;
                    sbit_valid <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr       <= sum_nxt;
                    b_sr       <= b_sr >> 1;
                    carry      <= carry_nxt;
                    sbit       <= bit_sum;
                    sbit_valid <= 1'b1;
                    cnt        <= cnt + 1'b1;
                    if (last_bit) begin
                        s     <= sum_nxt;
                        co    <= carry_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 16-bit instance checked
// cycle by cycle against plain-arithmetic expectations ({co,s} = A + B + ci).
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ci8 = 1'b0;
    logic        busy8, done8, co8, sbit8, sbit_valid8;
    logic [7:0]  s8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ci16 = 1'b0;
    logic        busy16, done16, co16, sbit16, sbit_valid16;
    logic [15:0] s16;

    int checks = 0;
    int failures = 0;

    bit          wide = 1'b0;
    logic [31:0] last_s8 = '0;
    logic        last_co8 = 1'b0;
    logic [31:0] last_s16 = '0;
    logic        last_co16 = 1'b0;

    logic        o_busy, o_done, o_co, o_sbit, o_sbit_valid;
    logic [31:0] o_s;

    assign o_busy       = wide ? busy16 : busy8;
    assign o_done       = wide ? done16 : done8;
    assign o_co         = wide ? co16 : co8;
    assign o_sbit       = wide ? sbit16 : sbit8;
    assign o_sbit_valid = wide ? sbit_valid16 : sbit_valid8;
    assign o_s          = wide ? {16'h0, s16} : {24'h0, s8};

    serial_adder #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8),
        .sbit(sbit8), .sbit_valid(sbit_valid8)
    );

    serial_adder #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .ci(ci16),
        .busy(busy16), .done(done16), .s(s16), .co(co16),
        .sbit(sbit16), .sbit_valid(sbit_valid16)
    );

    always #5 clk = ~clk;

    // One full addition on the selected instance. Entered and left at a negedge;
    // on return the DUT is in its DONE cycle so a following call is back-to-back.
    task automatic add_n(input bit w16, input logic [31:0] a_in, input logic [31:0] b_in,
                         input logic cin, input bit poke);
        int          w;
        logic [31:0] mask, a, b, exp_s, prev_s;
        logic [32:0] tot;
        logic        exp_co, prev_co;
        w      = w16 ? 16 : 8;
        mask   = (32'h1 << w) - 32'h1;
        a      = a_in & mask;
        b      = b_in & mask;
        tot    = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        exp_s  = tot[31:0] & mask;
        exp_co = tot[w];
        prev_s  = w16 ? last_s16 : last_s8;
        prev_co = w16 ? last_co16 : last_co8;
        wide = w16;
        if (w16) begin
            start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; ci16 = cin;
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; ci8 = cin;
        end
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_sbit_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_cycle w=%0d busy=%b done=%b sbit_valid=%b required 1,0,0",
                     w, o_busy, o_done, o_sbit_valid);
        end
        for (int k = 1; k <= w; k++) begin
            if (poke && k == 3) begin
                if (w16) begin start16 = 1'b1; a16 = 16'h1; b16 = 16'h1; end
                else begin start8 = 1'b1; a8 = 8'h1; b8 = 8'h1; end
            end
            if (poke && k == 4) begin
                start8 = 1'b0;
                start16 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (o_sbit_valid !== 1'b1 || o_sbit !== exp_s[k-1]) begin
                failures++;
                $display("FAIL sbit k=%0d valid=%b sbit=%b required valid=1 sbit=%b",
                         k, o_sbit_valid, o_sbit, exp_s[k-1]);
            end
            checks++;
            if (o_busy !== (k < w) || o_done !== (k == w)) begin
                failures++;
                $display("FAIL handshake k=%0d busy=%b done=%b required busy=%b done=%b",
                         k, o_busy, o_done, (k < w), (k == w));
            end
            if (k < w) begin
                checks++;
                if (o_s !== prev_s || o_co !== prev_co) begin
                    failures++;
                    $display("FAIL held_result k=%0d s=%h co=%b required s=%h co=%b",
                             k, o_s, o_co, prev_s, prev_co);
                end
            end else begin
                checks++;
                if (o_s !== exp_s || o_co !== exp_co) begin
                    failures++;
                    $display("FAIL result a=%h b=%h ci=%b s=%h co=%b required s=%h co=%b",
                             a, b, cin, o_s, o_co, exp_s, exp_co);
                end
            end
        end
        if (w16) begin last_s16 = exp_s; last_co16 = exp_co; end
        else begin last_s8 = exp_s; last_co8 = exp_co; end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_sbit_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle busy=%b done=%b sbit_valid=%b required 0,0,0",
                     o_busy, o_done, o_sbit_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wide = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 ||
                sbit_valid8 !== 1'b0 || busy16 !== 1'b0 || s16 !== 16'h0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d busy=%b done=%b s=%h co=%b sv=%b s16=%h required zeros",
                         i, busy8, done8, s8, co8, sbit_valid8, s16);
            end
        end
    endtask

    task automatic test_basic();
        add_n(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_boundary();
        add_n(1'b0, 32'hFF, 32'h00, 1'b1, 1'b0);
        idle_cycle();
        add_n(1'b0, 32'hFF, 32'hFF, 1'b1, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        add_n(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b1);
        add_n(1'b0, 32'h01, 32'h02, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        wide = 1'b0;
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5F; ci8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 ||
            sbit8 !== 1'b0 || sbit_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b s=%h co=%b sbit=%b sv=%b required zeros",
                     busy8, done8, s8, co8, sbit8, sbit_valid8);
        end
        last_s8 = '0; last_co8 = 1'b0; last_s16 = '0; last_co16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle_cycle();
        add_n(1'b0, 32'h80, 32'h80, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_wide();
        add_n(1'b1, 32'h1234, 32'hEDCC, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            add_n(($urandom_range(0, 3) == 0), $urandom, $urandom,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
